// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - fetch-to-decode instruction buffer with flush on taken jump
// Small FIFO of {inst, addr} pairs; decode sees the oldest entry or a NOP when empty.
module if_id_buf #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [31:0] NOP_INST   = 32'h00000001,
    parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic        jump_flag_i,
    input  logic        hold_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      addr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             push;
    logic             pop;
    logic             not_empty;
    logic             not_full;

    // Handshake outputs come from the registered count alone, so neither
    // hold_i nor jump_flag_i can reach inst_ready_o combinationally.
    assign not_empty    = (count_q != CNT_ZERO);
    assign not_full     = (count_q != CNT_FULL);
    assign inst_ready_o = not_full;
    assign inst_valid_o = not_empty;

    assign push = inst_valid_i & not_full  & ~jump_flag_i;
    assign pop  = not_empty    & ~hold_i   & ~jump_flag_i;

    assign inst_o      = not_empty ? inst_mem[rd_ptr_q] : NOP_INST;
    assign inst_addr_o = not_empty ? addr_mem[rd_ptr_q] : RESET_ADDR;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (jump_flag_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = CNT_ZERO;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; stale slots are masked by inst_valid_o.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= inst_i;
            addr_mem[wr_ptr_q] <= inst_addr_i;
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - self-checking bench for if_id_buf against a queue model
module tb_if_id_buf;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000001;
    localparam logic [31:0] RADDR = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic        jump_flag_i = 1'b0;
    logic        hold_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model_q [$];

    if_id_buf #(.DEPTH(DEPTH), .NOP_INST(NOP), .RESET_ADDR(RADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .inst_ready_o (inst_ready_o),
        .jump_flag_i  (jump_flag_i),
        .hold_i       (hold_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] head;
        head = (model_q.size() != 0) ? model_q[0] : {NOP, RADDR};
        check({tag, "_valid"}, 32'(inst_valid_o), 32'(model_q.size() != 0));
        check({tag, "_ready"}, 32'(inst_ready_o), 32'(model_q.size() < DEPTH));
        check({tag, "_inst"},  inst_o,      head[63:32]);
        check({tag, "_addr"},  inst_addr_o, head[31:0]);
    endtask

    // Called just after a falling edge: drive, clock once, model, check.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] adr,
                        input logic h, input logic j, input string tag);
        bit do_push, do_pop;
        inst_valid_i = v;
        inst_i       = ins;
        inst_addr_i  = adr;
        hold_i       = h;
        jump_flag_i  = j;
        #1;
        check({tag, "_ready_pre"}, 32'(inst_ready_o), 32'(model_q.size() < DEPTH));
        do_push = v && (model_q.size() < DEPTH) && !j;
        do_pop  = (model_q.size() != 0) && !h && !j;
        @(posedge clk);
        if (j) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({ins, adr});
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #1;
        check("rst0_valid", 32'(inst_valid_o), 32'd0);
        check("rst0_ready", 32'(inst_ready_o), 32'd1);
        check("rst0_inst",  inst_o,            NOP);
        check("rst0_addr",  inst_addr_o,       RADDR);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("post_rst");

        // In-order streaming with one-cycle visibility
        step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, "s1");
        check("s1_head", inst_o, 32'h00500093);
        step(1'b1, 32'h00A00113, 32'h4, 1'b0, 1'b0, "s2");
        check("s2_head", inst_o, 32'h00A00113);
        check("s2_addr", inst_addr_o, 32'h4);
        idle("s3");

        // Fill under hold, third instruction refused, drain in order
        step(1'b1, 32'h11111111, 32'h8,  1'b1, 1'b0, "f1");
        step(1'b1, 32'h22222222, 32'hC,  1'b1, 1'b0, "f2");
        check("f2_ready_low", 32'(inst_ready_o), 32'd0);
        step(1'b1, 32'h33333333, 32'h10, 1'b1, 1'b0, "f3");
        check("f3_head_kept", inst_addr_o, 32'h8);
        step(1'b1, 32'h33333333, 32'h10, 1'b0, 1'b0, "f4");
        check("f4_head", inst_addr_o, 32'hC);
        step(1'b1, 32'h33333333, 32'h10, 1'b0, 1'b0, "f5");
        check("f5_head", inst_addr_o, 32'h10);
        idle("f6");
        check("f6_empty", 32'(inst_valid_o), 32'd0);

        // Flush while full with a concurrent input
        step(1'b1, 32'h44444444, 32'h20, 1'b1, 1'b0, "j1");
        step(1'b1, 32'h55555555, 32'h24, 1'b1, 1'b0, "j2");
        step(1'b1, 32'h66666666, 32'h28, 1'b0, 1'b1, "j3");
        check("j3_valid", 32'(inst_valid_o), 32'd0);
        check("j3_inst",  inst_o,            NOP);
        check("j3_ready", 32'(inst_ready_o), 32'd1);
        idle("j4");
        check("j4_not_stored", 32'(inst_valid_o), 32'd0);

        // Simultaneous push/pop at count 1 across several pointer wraps
        step(1'b1, 32'h77770010, 32'h10, 1'b0, 1'b0, "p0");
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h77770014 + 32'(k), 32'h14 + 32'(4*k), 1'b0, 1'b0, "pk");
            check("pk_head", inst_addr_o, 32'h14 + 32'(4*k));
        end
        idle("p9");

        // Hold and flush together: flush wins
        step(1'b1, 32'h88888888, 32'h30, 1'b1, 1'b0, "h1");
        step(1'b1, 32'h99999999, 32'h34, 1'b1, 1'b0, "h2");
        step(1'b0, 32'h0,        32'h0,  1'b1, 1'b1, "h3");
        check("h3_empty", 32'(inst_valid_o), 32'd0);

        // Asynchronous reset mid-stream with two entries
        step(1'b1, 32'hAAAA0001, 32'h40, 1'b1, 1'b0, "r1");
        step(1'b1, 32'hAAAA0002, 32'h44, 1'b1, 1'b0, "r2");
        inst_valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_q.delete();
        check("rmid_valid", 32'(inst_valid_o), 32'd0);
        check("rmid_inst",  inst_o,            NOP);
        check("rmid_addr",  inst_addr_o,       RADDR);
        check("rmid_ready", 32'(inst_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("rpost");

        // Randomized traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(99) < 70, $urandom, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(99) < 30, $urandom_range(99) < 8, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
